// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Used by if_fifo and if_fetch_unit.
package if_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    typedef logic [InstAddrBus-1:0] inst_addr_t;
    typedef logic [InstBus-1:0]     inst_t;

    localparam inst_t      IF_NOP_INST = 32'h0;
    localparam inst_addr_t PC_INC      = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } if_state_e;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } if_id_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with occupancy count and flush.
// Serves both the prefetch buffer and the in-flight pc queue.
module if_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: PC generation, req/gnt ROM issue, prefetch FIFO, IF/ID register.
// Define IF_REDIRECT_EN to add redirect_i/redirect_pc_i with response discard.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter inst_addr_t RESET_PC   = 32'h0000_0000,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_req_o,
    output logic [InstAddrBus-1:0] rom_addr_o,
    input  logic                   rom_gnt_i,
    input  logic                   rom_rvalid_i,
    input  logic [InstBus-1:0]     rom_rdata_i,
    input  logic                   stall_i,
`ifdef IF_REDIRECT_EN
    input  logic                   redirect_i,
    input  logic [InstAddrBus-1:0] redirect_pc_i,
`endif
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   inst_valid_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if_state_e  state;
    if_state_e  state_nx;
    inst_addr_t pc;
    inst_addr_t q_head;
    inst_addr_t redirect_pc;
    if_id_t     f_in;
    if_id_t     f_out;
    logic       redirect;
    logic       fire;
    logic       resp;
    logic       keep;
    logic       bypass;
    logic       f_push;
    logic       f_pop;
    logic       f_empty;
    logic       f_full;
    logic       q_empty;
    logic       q_full;
    logic [CW-1:0] discard;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occ;

`ifdef IF_REDIRECT_EN
    assign redirect    = redirect_i;
    assign redirect_pc = redirect_pc_i;

    // Every response already owed at redirect time belongs to the old path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            discard <= '0;
        else if (redirect)
            discard <= inflight - CW'(resp);
        else if (resp && discard != '0)
            discard <= discard - CW'(1);
    end
`else
    assign redirect    = 1'b0;
    assign redirect_pc = RESET_PC;
    assign discard     = '0;
`endif

    assign occ    = {1'b0, inflight} + {1'b0, fifo_count};
    assign fire   = rom_req_o & rom_gnt_i;
    assign resp   = rom_rvalid_i & ~q_empty;
    assign keep   = resp & (discard == '0);
    assign bypass = ~redirect & ~stall_i & f_empty & keep;
    assign f_pop  = ~redirect & ~stall_i & ~f_empty;
    assign f_push = keep & ~bypass & ~redirect & ~f_full;
    assign f_in   = {q_head, rom_rdata_i};

    if_fifo #(
        .WIDTH ($bits(if_id_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (f_push),
        .push_data (f_in),
        .pop       (f_pop),
        .pop_data  (f_out),
        .count     (fifo_count),
        .full      (f_full),
        .empty     (f_empty)
    );

    if_fifo #(
        .WIDTH (InstAddrBus),
        .DEPTH (FIFO_DEPTH)
    ) u_inflight (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (fire),
        .push_data (pc),
        .pop       (resp),
        .pop_data  (q_head),
        .count     (inflight),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  state_nx = S_RUN;
            S_RUN:   if (redirect && inflight != '0) state_nx = S_DRAIN;
            S_DRAIN: if (inflight == '0) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    // Credit rule keeps outstanding plus buffered words within the FIFO.
    always_comb begin
        rom_req_o  = (state == S_RUN) & ~redirect & ~q_full
                   & (occ < (CW+1)'(FIFO_DEPTH));
        rom_addr_o = pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pc <= RESET_PC;
        else if (redirect)
            pc <= redirect_pc;
        else if (fire)
            pc <= pc + PC_INC;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_o         <= '0;
            inst_o       <= IF_NOP_INST;
            inst_valid_o <= 1'b0;
        end else if (redirect) begin
            pc_o         <= '0;
            inst_o       <= IF_NOP_INST;
            inst_valid_o <= 1'b0;
        end else if (stall_i) begin
            pc_o         <= pc_o;
            inst_o       <= inst_o;
            inst_valid_o <= inst_valid_o;
        end else if (!f_empty) begin
            pc_o         <= f_out.pc;
            inst_o       <= f_out.inst;
            inst_valid_o <= 1'b1;
        end else if (bypass) begin
            pc_o         <= q_head;
            inst_o       <= rom_rdata_i;
            inst_valid_o <= 1'b1;
        end else begin
            pc_o         <= '0;
            inst_o       <= IF_NOP_INST;
            inst_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand sequences, and
// randomized ROM timing against a queue-based stream model.
module tb_if_fetch_unit;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i = 1'b0;
    logic        rom_rvalid_i = 1'b0;
    logic [31:0] rom_rdata_i = '0;
    logic        stall_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
`ifdef IF_REDIRECT_EN
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
`endif

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .stall_i      (stall_i),
`ifdef IF_REDIRECT_EN
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
`endif
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    // Stream model: pending = granted but not answered; avail = answered
    // but not yet handed to ID. IF/ID takes the oldest available word.
    typedef struct {
        logic [31:0] addr;
        int          ready;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] avail[$];
    int          n_grant;
    int          n_load;
    int          cyc;
    bit          m_run;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        last_req;

    task automatic model_reset();
        pend.delete();
        avail.delete();
        n_grant = 0;
        n_load  = 0;
        cyc     = 0;
        m_run   = 0;
        e_addr  = 32'h0;
        e_pc    = 32'h0;
        e_inst  = 32'h0;
        e_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        stall_i      = 1'b0;
        rom_gnt_i    = 1'b0;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = '0;
`ifdef IF_REDIRECT_EN
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
`endif
        #1;
        chk("rst_req", 32'(rom_req_o), 32'h0);
        chk("rst_addr", rom_addr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_valid", 32'(inst_valid_o), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic mcycle(input logic st, input logic g, input int err_pct);
        logic        req_s;
        logic        resp;
        logic [63:0] w;
        stall_i      = st;
        rom_gnt_i    = g;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = $urandom;
        if (pend.size() > 0) begin
            if (pend[0].ready <= cyc && $urandom_range(3) != 0) begin
                rom_rvalid_i = 1'b1;
                rom_rdata_i  = rom(pend[0].addr);
            end
        end else if (int'($urandom_range(99)) < err_pct) begin
            rom_rvalid_i = 1'b1;
        end
        #1;
        chk("m_req", 32'(rom_req_o), 32'(m_run && (n_grant - n_load) < 4));
        chk("m_addr", rom_addr_o, e_addr);
        req_s    = rom_req_o;
        last_req = rom_req_o;
        @(posedge clk);
        resp = rom_rvalid_i && pend.size() > 0;
        w    = '0;
        if (resp) begin
            w = {pend[0].addr, rom_rdata_i};
            void'(pend.pop_front());
        end
        if (!st) begin
            if (avail.size() > 0) begin
                {e_pc, e_inst} = avail.pop_front();
                e_valid = 1'b1;
                n_load++;
                if (resp) avail.push_back(w);
            end else if (resp) begin
                {e_pc, e_inst} = w;
                e_valid = 1'b1;
                n_load++;
            end else begin
                e_pc    = 32'h0;
                e_inst  = 32'h0;
                e_valid = 1'b0;
            end
        end else if (resp) begin
            avail.push_back(w);
        end
        if (req_s && g) begin
            pend.push_back('{e_addr, cyc + 1 + int'($urandom_range(2))});
            e_addr = e_addr + 32'd4;
            n_grant++;
        end
        m_run = 1;
        cyc++;
        #1;
        chk("m_pc", pc_o, e_pc);
        chk("m_inst", inst_o, e_inst);
        chk("m_valid", 32'(inst_valid_o), 32'(e_valid));
    endtask

    typedef struct {
        logic        st;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tv[19];

`ifdef IF_REDIRECT_EN
    task automatic hcycle(input logic st, input logic g, input logic rv,
                          input logic [31:0] rd, input logic rdr,
                          input logic [31:0] rpc, output logic req,
                          output logic [31:0] addr);
        stall_i       = st;
        rom_gnt_i     = g;
        rom_rvalid_i  = rv;
        rom_rdata_i   = rd;
        redirect_i    = rdr;
        redirect_pc_i = rpc;
        #1;
        req  = rom_req_o;
        addr = rom_addr_o;
        @(posedge clk);
        #1;
        redirect_i = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{0, 1, 0, 32'h0,    0, 32'h00, 0, 32'h00, 32'h0};
        tv[1]  = '{0, 1, 0, 32'h0,    1, 32'h00, 0, 32'h00, 32'h0};
        tv[2]  = '{0, 1, 1, 32'h1,    1, 32'h04, 1, 32'h00, 32'h1};
        tv[3]  = '{0, 1, 1, 32'h2,    1, 32'h08, 1, 32'h04, 32'h2};
        tv[4]  = '{0, 0, 1, 32'h3,    1, 32'h0C, 1, 32'h08, 32'h3};
        tv[5]  = '{0, 0, 0, 32'h0,    1, 32'h0C, 0, 32'h00, 32'h0};
        tv[6]  = '{0, 0, 0, 32'h0,    1, 32'h0C, 0, 32'h00, 32'h0};
        tv[7]  = '{0, 0, 0, 32'h0,    1, 32'h0C, 0, 32'h00, 32'h0};
        tv[8]  = '{0, 0, 0, 32'h0,    1, 32'h0C, 0, 32'h00, 32'h0};
        tv[9]  = '{0, 1, 0, 32'h0,    1, 32'h0C, 0, 32'h00, 32'h0};
        tv[10] = '{0, 1, 0, 32'h0,    1, 32'h10, 0, 32'h00, 32'h0};
        tv[11] = '{0, 1, 0, 32'h0,    1, 32'h14, 0, 32'h00, 32'h0};
        tv[12] = '{1, 0, 1, 32'h4,    1, 32'h18, 0, 32'h00, 32'h0};
        tv[13] = '{0, 0, 1, 32'h5,    1, 32'h18, 1, 32'h0C, 32'h4};
        tv[14] = '{0, 0, 1, 32'h6,    1, 32'h18, 1, 32'h10, 32'h5};
        tv[15] = '{0, 0, 0, 32'h0,    1, 32'h18, 1, 32'h14, 32'h6};
        tv[16] = '{0, 0, 1, 32'hDEAD, 1, 32'h18, 0, 32'h00, 32'h0};
        tv[17] = '{0, 1, 0, 32'h0,    1, 32'h18, 0, 32'h00, 32'h0};
        tv[18] = '{0, 0, 1, 32'h7,    1, 32'h1C, 1, 32'h18, 32'h7};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            stall_i      = tv[i].st;
            rom_gnt_i    = tv[i].g;
            rom_rvalid_i = tv[i].rv;
            rom_rdata_i  = tv[i].rd;
            #1;
            chk($sformatf("t%0d_req", i), 32'(rom_req_o), 32'(tv[i].e_req));
            chk($sformatf("t%0d_addr", i), rom_addr_o, tv[i].e_addr);
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_valid", i), 32'(inst_valid_o), 32'(tv[i].e_val));
            chk($sformatf("t%0d_pc", i), pc_o, tv[i].e_pc);
            chk($sformatf("t%0d_inst", i), inst_o, tv[i].e_inst);
        end

        // Stall while streaming: IF/ID frozen, issue stops at four words.
        do_reset();
        repeat (6) mcycle(1'b0, 1'b1, 0);
        repeat (6) mcycle(1'b1, 1'b1, 0);
        chk("stall_credit", 32'(last_req), 32'h0);
        repeat (16) mcycle(1'b0, 1'b1, 0);

        // Randomized ROM timing, grants, stalls and stray rvalids.
        repeat (400)
            mcycle($urandom_range(9) < 3, $urandom_range(9) < 7, 5);

        // Asynchronous reset in the middle of a burst, then refetch from 0.
        repeat (8) mcycle(1'b0, 1'b1, 0);
        do_reset();
        repeat (40) mcycle($urandom_range(9) < 2, $urandom_range(9) < 8, 0);

`ifdef IF_REDIRECT_EN
        begin
            logic        r;
            logic [31:0] a;
            do_reset();
            hcycle(0, 1, 0, 32'h0, 0, 32'h0, r, a);
            hcycle(0, 1, 0, 32'h0, 0, 32'h0, r, a);
            hcycle(0, 1, 0, 32'h0, 0, 32'h0, r, a);
            chk("rd_pre_addr", a, 32'h4);
            hcycle(1, 1, 0, 32'h0, 1, 32'h100, r, a);
            chk("rd_cycle_req", 32'(r), 32'h0);
            chk("rd_bubble", 32'(inst_valid_o), 32'h0);
            hcycle(0, 1, 1, 32'h1, 0, 32'h0, r, a);
            chk("rd_drain_req0", 32'(r), 32'h0);
            chk("rd_drop0", 32'(inst_valid_o), 32'h0);
            hcycle(0, 1, 1, 32'h2, 0, 32'h0, r, a);
            chk("rd_drain_req1", 32'(r), 32'h0);
            chk("rd_drop1", 32'(inst_valid_o), 32'h0);
            hcycle(0, 0, 0, 32'h0, 0, 32'h0, r, a);
            chk("rd_drop2", 32'(inst_valid_o), 32'h0);
            hcycle(0, 1, 0, 32'h0, 0, 32'h0, r, a);
            chk("rd_resume_req", 32'(r), 32'h1);
            chk("rd_resume_addr", a, 32'h100);
            hcycle(0, 0, 1, 32'h41, 0, 32'h0, r, a);
            chk("rd_new_pc", pc_o, 32'h100);
            chk("rd_new_inst", inst_o, 32'h41);
            chk("rd_new_valid", 32'(inst_valid_o), 32'h1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
